uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_sync.sv | 13 +
 rtl/uart_receiver.sv | 97 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and frame constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
  localparam int DATA_BITS = 8;
  localparam logic STOP_LEVEL = 1'b1;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: STAGES-flop synchronizer presetting to 1 (line idle); ports CLK, Reset, d (async in), q (synced out)
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic Reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s;
  always_ff @(posedge CLK) s <= Reset ? '1 : {s[STAGES-2:0], d};
  assign q = s[STAGES-1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, MSB first; ports CLK, Reset, rx, DataOUT/Valid/Ready holding register, FrameErr, Overrun, Busy
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] DataOUT,
  output logic                 Valid,
  input  logic                 Ready,
  output logic                 FrameErr,
  output logic                 Overrun,
  output logic                 Busy
);
  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int BW   = $clog2(DATA_BITS);
  localparam int HALF = CLKS_PER_BIT / 2;
  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bits, bits_n;
  logic [DATA_BITS-1:0] sh, sh_n, data_n;
  logic valid_n, ferr_n, ovr_n, rx_s, tick, good;
  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (.CLK(CLK), .Reset(Reset), .d(rx), .q(rx_s));
  // cnt reads 0 on the reference cycle (t0 or a sample point), so it equals the
  // number of cycles elapsed since then; a bit sample falls due at CLKS_PER_BIT
  assign tick = cnt == CW'(CLKS_PER_BIT);
  assign good = state == STOP && tick && rx_s == STOP_LEVEL;
  assign Busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bits_n  = bits;
    sh_n    = sh;
    data_n  = DataOUT;
    valid_n = Valid && !Ready;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
    case (state)
      // with HALF = 0 the start recheck coincides with t0, so START is skipped
      IDLE: begin
        state_n = rx_s ? IDLE : (HALF == 0 ? DATA : START);
        cnt_n   = rx_s ? '0 : CW'(1);
        bits_n  = '0;
      end
      START: if (cnt == CW'(HALF)) begin
        state_n = rx_s ? IDLE : DATA;
        cnt_n   = rx_s ? '0 : CW'(1);
      end
      DATA: if (tick) begin
        sh_n    = {sh[DATA_BITS-2:0], rx_s};
        cnt_n   = CW'(1);
        bits_n  = bits + BW'(1);
        state_n = bits == BW'(DATA_BITS - 1) ? STOP : DATA;
      end
      STOP: if (tick) begin
        state_n = rx_s == STOP_LEVEL ? IDLE : WAIT_IDLE;
        cnt_n   = '0;
        ferr_n  = rx_s != STOP_LEVEL;
      end
      WAIT_IDLE: begin
        state_n = rx_s ? IDLE : WAIT_IDLE;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
    // a full register being read this very cycle still has room for the new byte
    if (good) begin
      data_n  = (!Valid || Ready) ? sh : DataOUT;
      valid_n = 1'b1;
      ovr_n   = Valid && !Ready;
    end
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bits     <= '0;
      sh       <= '0;
      DataOUT  <= '0;
      Valid    <= 1'b0;
      FrameErr <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bits     <= bits_n;
      sh       <= sh_n;
      DataOUT  <= data_n;
      Valid    <= valid_n;
      FrameErr <= ferr_n;
      Overrun  <= ovr_n;
    end
  end
endmodule
